// File: rtl/kgp_rf_pkg.sv
// Shared register-file constants and index type for the datapath, decode and hazard units.
package kgp_rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    // Index of the optionally hardwired-zero register.
    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, looked up per read port.
module rf_scoreboard
    import kgp_rf_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned NUM_RD    = NUM_RD_DEF,
    parameter bit          ZERO_REG0 = 1'b0,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_idx,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_idx,
    input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_IDX);

    logic [DEPTH-1:0] busy;
    logic             rsv_en;
    logic             fwd_ok;

    // Reservations of a hardwired-zero r0 are dropped; a same-reg reserve blocks the retire forward.
    always_comb begin
        rsv_en = rsv && !(ZERO_REG0 && rsv_idx == R0);
        fwd_ok = BYPASS && wr_en && !(rsv_en && rsv_idx == wr_idx);
    end

    // Busy vector: retire clears, reserve sets; reserve is applied last so the new producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[wr_idx] <= 1'b0;
            end
            if (rsv_en) begin
                busy[rsv_idx] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [ADDR_W-1:0] idx;
        logic              b;

        assign idx = rd_idx[k*ADDR_W +: ADDR_W];

        // Per-port lookup with retire-cycle forwarding and zero-register masking.
        always_comb begin
            b = busy[idx];
            if (fwd_ok && idx == wr_idx) begin
                b = 1'b0;
            end
            if (ZERO_REG0 && idx == R0) begin
                b = 1'b0;
            end
        end

        assign rd_busy[k] = b;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero r0, write bypass, debug readout and scoreboard.
module regfile_mp
    import kgp_rf_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned NUM_RD    = NUM_RD_DEF,
    parameter bit          ZERO_REG0 = 1'b0,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteReg,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadBusy,
    input  logic                     Reserve,
    input  logic [ADDR_W-1:0]        ReserveReg,
    input  logic [ADDR_W-1:0]        DbgReg,
    output logic [DATA_W-1:0]        rout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] dbg_data;

    // Qualified write enable and debug source (pre-write contents).
    always_comb begin
        wr_en    = RegWrite && !(ZERO_REG0 && WriteReg == R0);
        dbg_data = mem[DbgReg];
        if (ZERO_REG0 && DbgReg == R0) begin
            dbg_data = '0;
        end
    end

    // Storage array and registered debug readout.
    always_ff @(posedge Clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rout <= '0;
        end else begin
            if (wr_en) begin
                mem[WriteReg] <= WriteData;
            end
            rout <= dbg_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] rd;

        assign idx = ReadReg[k*ADDR_W +: ADDR_W];

        // Asynchronous read mux with optional same-cycle forward; zero r0 overrides everything.
        always_comb begin
            rd = mem[idx];
            if (BYPASS && wr_en && idx == WriteReg) begin
                rd = WriteData;
            end
            if (ZERO_REG0 && idx == R0) begin
                rd = '0;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rd;
    end

    rf_scoreboard #(
        .ADDR_W    (ADDR_W),
        .NUM_RD    (NUM_RD),
        .ZERO_REG0 (ZERO_REG0),
        .BYPASS    (BYPASS)
    ) u_sb (
        .clk     (Clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (WriteReg),
        .rsv     (Reserve),
        .rsv_idx (ReserveReg),
        .rd_idx  (ReadReg),
        .rd_busy (ReadBusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations share stimulus, checked against a per-register model.
module tb_regfile_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            rst;
    logic            RegWrite;
    logic [AW-1:0]   WriteReg;
    logic [DW-1:0]   WriteData;
    logic            Reserve;
    logic [AW-1:0]   ReserveReg;
    logic [AW-1:0]   DbgReg;

    // Instance a: 2 ports, r0 normal, bypass on. Instance b: 4 ports, r0 zero, bypass off.
    logic [2*AW-1:0] rr_a;
    logic [2*DW-1:0] rd_a;
    logic [1:0]      rb_a;
    logic [DW-1:0]   rout_a;
    logic [4*AW-1:0] rr_b;
    logic [4*DW-1:0] rd_b;
    logic [3:0]      rb_b;
    logic [DW-1:0]   rout_b;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG0(1'b0), .BYPASS(1'b1)) dut_a (
        .Clk(Clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg(rr_a), .ReadData(rd_a), .ReadBusy(rb_a), .Reserve(Reserve),
        .ReserveReg(ReserveReg), .DbgReg(DbgReg), .rout(rout_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG0(1'b1), .BYPASS(1'b0)) dut_b (
        .Clk(Clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg(rr_b), .ReadData(rd_b), .ReadBusy(rb_b), .Reserve(Reserve),
        .ReserveReg(ReserveReg), .DbgReg(DbgReg), .rout(rout_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, pending flags and debug copy for each configuration.
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            m_busy [2][DEPTH];
    logic [DW-1:0] m_rout [2];
    bit            cfg_zero [2] = '{1'b0, 1'b1};
    bit            cfg_byp  [2] = '{1'b1, 1'b0};

    function automatic bit write_live(int d);
        return RegWrite && !(cfg_zero[d] && WriteReg == 0);
    endfunction

    function automatic bit reserve_live(int d);
        return Reserve && !(cfg_zero[d] && ReserveReg == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data(int d, logic [AW-1:0] idx);
        if (cfg_zero[d] && idx == 0) return '0;
        if (cfg_byp[d] && write_live(d) && idx == WriteReg) return WriteData;
        return m_mem[d][idx];
    endfunction

    function automatic logic exp_busy(int d, logic [AW-1:0] idx);
        if (cfg_zero[d] && idx == 0) return 1'b0;
        if (cfg_byp[d] && write_live(d) && idx == WriteReg &&
            !(reserve_live(d) && ReserveReg == WriteReg)) return 1'b0;
        return m_busy[d][idx];
    endfunction

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    m_mem[d][i]  = '0;
                    m_busy[d][i] = 1'b0;
                end
                m_rout[d] = '0;
            end else begin
                m_rout[d] = (cfg_zero[d] && DbgReg == 0) ? '0 : m_mem[d][DbgReg];
                if (write_live(d)) begin
                    m_mem[d][WriteReg]  = WriteData;
                    m_busy[d][WriteReg] = 1'b0;
                end
                if (reserve_live(d)) m_busy[d][ReserveReg] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic set_idle();
        rst = 1'b0; RegWrite = 1'b0; Reserve = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_idx();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs(int rst_odds);
        rst        = ($urandom_range(0, rst_odds) == 0);
        RegWrite   = $urandom_range(0, 1) == 1;
        WriteReg   = pick_idx();
        WriteData  = $urandom;
        Reserve    = $urandom_range(0, 2) == 0;
        ReserveReg = ($urandom_range(0, 3) == 0) ? WriteReg : pick_idx();
        DbgReg     = pick_idx();
        for (int k = 0; k < 2; k++) rr_a[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? WriteReg : pick_idx();
        for (int k = 0; k < 4; k++) rr_b[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? WriteReg : pick_idx();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 12; c++) begin
            rand_inputs(1000);
            rst = 1'b0;
            cycle();
        end
        rst = 1'b1; RegWrite = 1'b1; Reserve = 1'b1;
        cycle();
        cycle();
        set_idle();
        rr_a = {5'd1, 5'd7};
        rr_b = {5'd3, 5'd2, 5'd1, 5'd7};
        #1;
        checks++; if (rd_a !== '0)   begin errors++; $display("FAIL reset_rd_a got %h exp 0", rd_a); end
        checks++; if (rb_a !== '0)   begin errors++; $display("FAIL reset_rb_a got %b exp 0", rb_a); end
        checks++; if (rout_a !== '0) begin errors++; $display("FAIL reset_rout_a got %h exp 0", rout_a); end
        checks++; if (rd_b !== '0)   begin errors++; $display("FAIL reset_rd_b got %h exp 0", rd_b); end
        checks++; if (rb_b !== '0)   begin errors++; $display("FAIL reset_rb_b got %b exp 0", rb_b); end
        checks++; if (rout_b !== '0) begin errors++; $display("FAIL reset_rout_b got %h exp 0", rout_b); end
    endtask

    task automatic test_write_read();
        set_idle();
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'd4;
        cycle();
        WriteReg = 5'd1; WriteData = 32'd5;
        cycle();
        set_idle();
        rr_a = {5'd1, 5'd0};
        rr_b = {5'd0, 5'd0, 5'd1, 5'd0};
        #1;
        checks++; if (rd_a !== {32'd5, 32'd4}) begin errors++; $display("FAIL wr_rd_a got %h exp %h", rd_a, {32'd5, 32'd4}); end
        checks++; if (rd_b[31:0] !== 32'd0)    begin errors++; $display("FAIL wr_r0_zero_b got %h exp 0", rd_b[31:0]); end
        checks++; if (rd_b[63:32] !== 32'd5)   begin errors++; $display("FAIL wr_r1_b got %h exp 5", rd_b[63:32]); end
    endtask

    task automatic test_bypass();
        set_idle();
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h1111_1111;
        cycle();
        WriteData = 32'hDEAD_BEEF;
        rr_a = {5'd1, 5'd3};
        rr_b = {5'd0, 5'd0, 5'd0, 5'd3};
        #1;
        checks++; if (rd_a[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_a got %h exp deadbeef", rd_a[31:0]); end
        checks++; if (rd_b[31:0] !== 32'h1111_1111) begin errors++; $display("FAIL nobypass_b got %h exp 11111111", rd_b[31:0]); end
        cycle();
        set_idle();
        #1;
        checks++; if (rd_b[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_landed_b got %h exp deadbeef", rd_b[31:0]); end
    endtask

    task automatic test_scoreboard();
        set_idle();
        Reserve = 1'b1; ReserveReg = 5'd7;
        cycle();
        set_idle();
        rr_a = {5'd7, 5'd7};
        rr_b = {5'd0, 5'd0, 5'd1, 5'd7};
        #1;
        checks++; if (rb_a !== 2'b11)    begin errors++; $display("FAIL sb_set_a got %b exp 11", rb_a); end
        checks++; if (rb_b !== 4'b0001)  begin errors++; $display("FAIL sb_set_b got %b exp 0001", rb_b); end
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'd9;
        #1;
        checks++; if (rb_a !== 2'b00)    begin errors++; $display("FAIL sb_retire_fwd_a got %b exp 00", rb_a); end
        checks++; if (rb_b[0] !== 1'b1)  begin errors++; $display("FAIL sb_retire_nofwd_b got %b exp 1", rb_b[0]); end
        checks++; if (rd_a[31:0] !== 32'd9) begin errors++; $display("FAIL sb_retire_data_a got %h exp 9", rd_a[31:0]); end
        cycle();
        set_idle();
        #1;
        checks++; if (rb_b[0] !== 1'b0)  begin errors++; $display("FAIL sb_clear_b got %b exp 0", rb_b[0]); end
        checks++; if (rd_b[31:0] !== 32'd9) begin errors++; $display("FAIL sb_data_b got %h exp 9", rd_b[31:0]); end
    endtask

    task automatic test_simultaneous();
        set_idle();
        Reserve = 1'b1; ReserveReg = 5'd7;
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'd11;
        cycle();
        set_idle();
        rr_a = {5'd7, 5'd7};
        rr_b = {5'd0, 5'd0, 5'd0, 5'd7};
        #1;
        checks++; if (rd_a[31:0] !== 32'd11) begin errors++; $display("FAIL simul_data_a got %h exp 11", rd_a[31:0]); end
        checks++; if (rb_a[0] !== 1'b1)      begin errors++; $display("FAIL simul_busy_a got %b exp 1", rb_a[0]); end
        checks++; if (rb_b[0] !== 1'b1)      begin errors++; $display("FAIL simul_busy_b got %b exp 1", rb_b[0]); end
        Reserve = 1'b1; ReserveReg = 5'd0;
        cycle();
        set_idle();
        rr_a = {5'd7, 5'd0};
        rr_b = {5'd0, 5'd0, 5'd7, 5'd0};
        #1;
        checks++; if (rb_a !== 2'b11)   begin errors++; $display("FAIL rsv_r0_a got %b exp 11", rb_a); end
        checks++; if (rb_b !== 4'b0010) begin errors++; $display("FAIL rsv_r0_b got %b exp 0010", rb_b); end
        rst = 1'b1;
        cycle();
        set_idle();
        #1;
        checks++; if (rb_a !== 2'b00)        begin errors++; $display("FAIL simul_rst_busy_a got %b exp 00", rb_a); end
        checks++; if (rd_a[63:32] !== 32'd0) begin errors++; $display("FAIL simul_rst_data_a got %h exp 0", rd_a[63:32]); end
    endtask

    task automatic test_debug();
        set_idle();
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h55; DbgReg = 5'd5;
        cycle();
        #1;
        checks++; if (rout_a !== 32'd0) begin errors++; $display("FAIL dbg_prewrite_a got %h exp 0", rout_a); end
        set_idle();
        rr_b = {5'd5, 5'd5, 5'd5, 5'd5};
        cycle();
        #1;
        checks++; if (rout_a !== 32'h55) begin errors++; $display("FAIL dbg_a got %h exp 55", rout_a); end
        checks++; if (rout_b !== 32'h55) begin errors++; $display("FAIL dbg_b got %h exp 55", rout_b); end
        checks++; if (rd_b !== {4{32'h55}}) begin errors++; $display("FAIL allports_b got %h exp %h", rd_b, {4{32'h55}}); end
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h77; DbgReg = 5'd0;
        cycle();
        set_idle();
        cycle();
        #1;
        checks++; if (rout_a !== 32'h77) begin errors++; $display("FAIL dbg_r0_a got %h exp 77", rout_a); end
        checks++; if (rout_b !== 32'd0)  begin errors++; $display("FAIL dbg_r0_b got %h exp 0", rout_b); end
    endtask

    task automatic test_random(int n);
        for (int c = 0; c < n; c++) begin
            rand_inputs(40);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd_a[k*DW +: DW] !== exp_data(0, rr_a[k*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_data_a cyc%0d port%0d got %h exp %h", c, k, rd_a[k*DW +: DW], exp_data(0, rr_a[k*AW +: AW]));
                end
                checks++;
                if (rb_a[k] !== exp_busy(0, rr_a[k*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_busy_a cyc%0d port%0d got %b exp %b", c, k, rb_a[k], exp_busy(0, rr_a[k*AW +: AW]));
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_b[k*DW +: DW] !== exp_data(1, rr_b[k*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_data_b cyc%0d port%0d got %h exp %h", c, k, rd_b[k*DW +: DW], exp_data(1, rr_b[k*AW +: AW]));
                end
                checks++;
                if (rb_b[k] !== exp_busy(1, rr_b[k*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_busy_b cyc%0d port%0d got %b exp %b", c, k, rb_b[k], exp_busy(1, rr_b[k*AW +: AW]));
                end
            end
            checks++;
            if (rout_a !== m_rout[0]) begin errors++; $display("FAIL rand_rout_a cyc%0d got %h exp %h", c, rout_a, m_rout[0]); end
            checks++;
            if (rout_b !== m_rout[1]) begin errors++; $display("FAIL rand_rout_b cyc%0d got %h exp %h", c, rout_b, m_rout[1]); end
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; Reserve = 1'b0;
        WriteReg = '0; WriteData = '0; ReserveReg = '0; DbgReg = '0;
        rr_a = '0; rr_b = '0;
        @(negedge Clk);
        cycle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_debug();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
